// File: rtl/control_pipe_if.sv
// Bundle between the ID-stage instruction source and the EX/MEM/WB control consumers.
// The master side is the main control unit that decodes and pipelines control bits.
interface control_pipe_if;
    logic [31:0] instr_id;
    logic        stall;
    logic        flush;
    logic [1:0]  aluop_ex;
    logic [31:0] signext_ex;
    logic        alusrc_ex;
    logic        regdst_ex;
    logic        memread_mem;
    logic        memwrite_mem;
    logic        branch_mem;
    logic        regwrite_wb;
    logic        memtoreg_wb;
    logic        valid_ex;
    logic        valid_mem;
    logic        valid_wb;
    logic        illegal_ex;

    modport master (
        input  instr_id, stall, flush,
        output aluop_ex, signext_ex, alusrc_ex, regdst_ex,
               memread_mem, memwrite_mem, branch_mem,
               regwrite_wb, memtoreg_wb,
               valid_ex, valid_mem, valid_wb, illegal_ex
    );

    modport slave (
        output instr_id, stall, flush,
        input  aluop_ex, signext_ex, alusrc_ex, regdst_ex,
               memread_mem, memwrite_mem, branch_mem,
               regwrite_wb, memtoreg_wb,
               valid_ex, valid_mem, valid_wb, illegal_ex
    );
endinterface

// File: rtl/control_pipe.sv
// Main control for the 5-stage MIPS pipeline: decodes the ID opcode and carries the
// control bundle through ID/EX, EX/MEM and MEM/WB with bubble and squash handling.
module control_pipe #(
    parameter bit FLUSH_EXMEM = 1'b1,
    parameter bit ENABLE_ADDI = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    control_pipe_if.master bus
);
    logic [5:0]  opcode;
    logic [31:0] signext;
    logic        dec_regdst, dec_alusrc, dec_memtoreg, dec_regwrite;
    logic        dec_memread, dec_memwrite, dec_branch, dec_illegal;
    logic [1:0]  dec_aluop;

    assign opcode  = bus.instr_id[31:26];
    assign signext = {{16{bus.instr_id[15]}}, bus.instr_id[15:0]};

    always_comb begin
        dec_regdst   = 1'b0;
        dec_alusrc   = 1'b0;
        dec_memtoreg = 1'b0;
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_branch   = 1'b0;
        dec_aluop    = 2'b00;
        dec_illegal  = 1'b0;
        case (opcode)
            6'b000000: begin
                dec_regdst   = 1'b1;
                dec_regwrite = 1'b1;
                dec_aluop    = 2'b10;
            end
            6'b100011: begin
                dec_alusrc   = 1'b1;
                dec_memtoreg = 1'b1;
                dec_regwrite = 1'b1;
                dec_memread  = 1'b1;
            end
            6'b101011: begin
                dec_alusrc   = 1'b1;
                dec_memwrite = 1'b1;
            end
            6'b000100: begin
                dec_branch = 1'b1;
                dec_aluop  = 2'b01;
            end
            6'b001000: begin
                if (ENABLE_ADDI) begin
                    dec_alusrc   = 1'b1;
                    dec_regwrite = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // ID/EX stage
    logic [1:0]  aluop_reg;
    logic [31:0] signext_reg;
    logic        alusrc_reg, regdst_reg, valid_ex_reg, illegal_reg;
    logic        memread_idex_reg, memwrite_idex_reg, branch_idex_reg;
    logic        regwrite_idex_reg, memtoreg_idex_reg;

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            aluop_reg         <= 2'b00;
            signext_reg       <= 32'd0;
            alusrc_reg        <= 1'b0;
            regdst_reg        <= 1'b0;
            valid_ex_reg      <= 1'b0;
            illegal_reg       <= 1'b0;
            memread_idex_reg  <= 1'b0;
            memwrite_idex_reg <= 1'b0;
            branch_idex_reg   <= 1'b0;
            regwrite_idex_reg <= 1'b0;
            memtoreg_idex_reg <= 1'b0;
        end else if (bus.stall) begin
            // Bubble: controls cleared, immediate still captured (don't-care).
            aluop_reg         <= 2'b00;
            signext_reg       <= signext;
            alusrc_reg        <= 1'b0;
            regdst_reg        <= 1'b0;
            valid_ex_reg      <= 1'b0;
            illegal_reg       <= 1'b0;
            memread_idex_reg  <= 1'b0;
            memwrite_idex_reg <= 1'b0;
            branch_idex_reg   <= 1'b0;
            regwrite_idex_reg <= 1'b0;
            memtoreg_idex_reg <= 1'b0;
        end else begin
            aluop_reg         <= dec_aluop;
            signext_reg       <= signext;
            alusrc_reg        <= dec_alusrc;
            regdst_reg        <= dec_regdst;
            valid_ex_reg      <= 1'b1;
            illegal_reg       <= dec_illegal;
            memread_idex_reg  <= dec_memread;
            memwrite_idex_reg <= dec_memwrite;
            branch_idex_reg   <= dec_branch;
            regwrite_idex_reg <= dec_regwrite;
            memtoreg_idex_reg <= dec_memtoreg;
        end
    end

    // EX/MEM stage; squashed too when the branch resolves in MEM.
    logic memread_mem_reg, memwrite_mem_reg, branch_mem_reg;
    logic regwrite_exmem_reg, memtoreg_exmem_reg, valid_mem_reg;

    always_ff @(posedge clk) begin
        if (reset || (bus.flush && FLUSH_EXMEM)) begin
            memread_mem_reg    <= 1'b0;
            memwrite_mem_reg   <= 1'b0;
            branch_mem_reg     <= 1'b0;
            regwrite_exmem_reg <= 1'b0;
            memtoreg_exmem_reg <= 1'b0;
            valid_mem_reg      <= 1'b0;
        end else begin
            memread_mem_reg    <= memread_idex_reg;
            memwrite_mem_reg   <= memwrite_idex_reg;
            branch_mem_reg     <= branch_idex_reg;
            regwrite_exmem_reg <= regwrite_idex_reg;
            memtoreg_exmem_reg <= memtoreg_idex_reg;
            valid_mem_reg      <= valid_ex_reg;
        end
    end

    // MEM/WB stage always advances so a resolving branch still retires.
    logic regwrite_wb_reg, memtoreg_wb_reg, valid_wb_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_wb_reg <= 1'b0;
            memtoreg_wb_reg <= 1'b0;
            valid_wb_reg    <= 1'b0;
        end else begin
            regwrite_wb_reg <= regwrite_exmem_reg;
            memtoreg_wb_reg <= memtoreg_exmem_reg;
            valid_wb_reg    <= valid_mem_reg;
        end
    end

    assign bus.aluop_ex     = aluop_reg;
    assign bus.signext_ex   = signext_reg;
    assign bus.alusrc_ex    = alusrc_reg;
    assign bus.regdst_ex    = regdst_reg;
    assign bus.valid_ex     = valid_ex_reg;
    assign bus.illegal_ex   = illegal_reg;
    assign bus.memread_mem  = memread_mem_reg;
    assign bus.memwrite_mem = memwrite_mem_reg;
    assign bus.branch_mem   = branch_mem_reg;
    assign bus.valid_mem    = valid_mem_reg;
    assign bus.regwrite_wb  = regwrite_wb_reg;
    assign bus.memtoreg_wb  = memtoreg_wb_reg;
    assign bus.valid_wb     = valid_wb_reg;
endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: two instances (default and FLUSH_EXMEM=0/ENABLE_ADDI=0) driven
// identically and compared against a stage-record reference model each cycle.
module tb_control_pipe;
    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        stall;
    logic        flush;

    int checks   = 0;
    int failures = 0;

    control_pipe_if if0 ();
    control_pipe_if if1 ();

    assign if0.instr_id = instr;
    assign if0.stall    = stall;
    assign if0.flush    = flush;
    assign if1.instr_id = instr;
    assign if1.stall    = stall;
    assign if1.flush    = flush;

    control_pipe #(.FLUSH_EXMEM(1'b1), .ENABLE_ADDI(1'b1)) dut0 (
        .clk(clk), .reset(rst), .bus(if0.master)
    );
    control_pipe #(.FLUSH_EXMEM(1'b0), .ENABLE_ADDI(1'b0)) dut1 (
        .clk(clk), .reset(rst), .bus(if1.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic        sxcare;
        logic [31:0] signext;
        logic        regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch;
        logic [1:0]  aluop;
    } bundle_t;

    bundle_t m_ex [2];
    bundle_t m_mem[2];
    bundle_t m_wb [2];

    // Control table straight from the opcode list.
    function automatic bundle_t decode(logic [31:0] ins, bit addi_en);
        bundle_t b;
        logic [8:0] ctl;
        b = '0;
        b.valid   = 1'b1;
        b.sxcare  = 1'b1;
        b.signext = {{16{ins[15]}}, ins[15:0]};
        ctl = 9'b0;
        case (ins[31:26])
            6'h00: ctl = 9'b1_0_0_1_0_0_0_10;
            6'h23: ctl = 9'b0_1_1_1_1_0_0_00;
            6'h2B: ctl = 9'b0_1_0_0_0_1_0_00;
            6'h04: ctl = 9'b0_0_0_0_0_0_1_01;
            6'h08: if (addi_en) ctl = 9'b0_1_0_1_0_0_0_00; else b.illegal = 1'b1;
            default: b.illegal = 1'b1;
        endcase
        {b.regdst, b.alusrc, b.memtoreg, b.regwrite, b.memread, b.memwrite, b.branch, b.aluop} = ctl;
        return b;
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_ex[k] = '0; m_ex[k].sxcare = 1'b1;
                m_mem[k] = '0;
                m_wb[k]  = '0;
            end else begin
                m_wb[k]  = m_mem[k];
                m_mem[k] = (flush && k == 0) ? '0 : m_ex[k];
                if (flush || stall) m_ex[k] = '0;
                else                m_ex[k] = decode(instr, k == 0);
            end
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            logic [5:0]  ex_o;
            logic [31:0] sx_o;
            logic [3:0]  mem_o;
            logic [2:0]  wb_o;
            if (k == 0) begin
                ex_o  = {if0.valid_ex, if0.illegal_ex, if0.aluop_ex, if0.alusrc_ex, if0.regdst_ex};
                sx_o  = if0.signext_ex;
                mem_o = {if0.valid_mem, if0.memread_mem, if0.memwrite_mem, if0.branch_mem};
                wb_o  = {if0.valid_wb, if0.regwrite_wb, if0.memtoreg_wb};
            end else begin
                ex_o  = {if1.valid_ex, if1.illegal_ex, if1.aluop_ex, if1.alusrc_ex, if1.regdst_ex};
                sx_o  = if1.signext_ex;
                mem_o = {if1.valid_mem, if1.memread_mem, if1.memwrite_mem, if1.branch_mem};
                wb_o  = {if1.valid_wb, if1.regwrite_wb, if1.memtoreg_wb};
            end
            chk($sformatf("ex_ctl[%0d]", k), 64'(ex_o),
                64'({m_ex[k].valid, m_ex[k].illegal, m_ex[k].aluop, m_ex[k].alusrc, m_ex[k].regdst}));
            if (m_ex[k].sxcare)
                chk($sformatf("signext[%0d]", k), 64'(sx_o), 64'(m_ex[k].signext));
            chk($sformatf("mem_ctl[%0d]", k), 64'(mem_o),
                64'({m_mem[k].valid, m_mem[k].memread, m_mem[k].memwrite, m_mem[k].branch}));
            chk($sformatf("wb_ctl[%0d]", k), 64'(wb_o),
                64'({m_wb[k].valid, m_wb[k].regwrite, m_wb[k].memtoreg}));
        end
    endtask

    task automatic step(logic [31:0] ins, bit st, bit fl, bit rs);
        instr = ins;
        stall = st;
        flush = fl;
        rst   = rs;
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    localparam logic [31:0] ADD  = 32'h012A4020;
    localparam logic [31:0] DEP  = 32'h01095020;
    localparam logic [31:0] LW   = 32'h8D090004;
    localparam logic [31:0] LWN  = 32'h8D09FFFC;
    localparam logic [31:0] SW   = 32'hAD090008;
    localparam logic [31:0] BEQ  = 32'h11090003;
    localparam logic [31:0] ADDI = 32'h21090005;
    localparam logic [31:0] ILL  = 32'hFC000000;

    initial begin
        logic [5:0] op;
        clk = 1'b0;

        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(32'd0, 1'b0, 1'b0, 1'b1);
        chk("reset_valid_ex", 64'(if0.valid_ex), 64'd0);

        step(ADD, 1'b0, 1'b0, 1'b0);
        chk("add_aluop", 64'(if0.aluop_ex), 64'd2);
        chk("add_regdst_alusrc", 64'({if0.regdst_ex, if0.alusrc_ex}), 64'b10);
        chk("add_funct", 64'(if0.signext_ex[5:0]), 64'b100000);

        step(LW, 1'b0, 1'b0, 1'b0);
        chk("lw_signext", 64'(if0.signext_ex), 64'h4);
        chk("lw_alusrc", 64'(if0.alusrc_ex), 64'd1);
        step(LWN, 1'b0, 1'b0, 1'b0);
        chk("lw_signext_neg", 64'(if0.signext_ex), 64'hFFFFFFFC);
        chk("add_wb", 64'({if0.regwrite_wb, if0.memtoreg_wb}), 64'b10);

        step(DEP, 1'b1, 1'b0, 1'b0);
        chk("bubble_ex", 64'(if0.valid_ex), 64'd0);
        step(DEP, 1'b0, 1'b0, 1'b0);
        chk("lw_wb", 64'({if0.regwrite_wb, if0.memtoreg_wb}), 64'b11);
        step(BEQ, 1'b0, 1'b0, 1'b0);
        chk("bubble_wb", 64'({if0.valid_wb, if0.regwrite_wb}), 64'd0);

        step(SW, 1'b0, 1'b0, 1'b0);
        step(ADD, 1'b0, 1'b1, 1'b0);
        chk("flush_exmem_mem", 64'({if0.valid_mem, if0.memwrite_mem}), 64'd0);
        chk("flush_ex_only_mem", 64'({if1.valid_mem, if1.memwrite_mem}), 64'b11);
        chk("flush_ex_cleared", 64'({if0.valid_ex, if1.valid_ex}), 64'd0);

        step(SW, 1'b1, 1'b1, 1'b0);
        chk("stall_flush_ex", 64'(if0.valid_ex), 64'd0);

        step(SW, 1'b0, 1'b0, 1'b0);
        step(ADD, 1'b0, 1'b0, 1'b1);
        chk("midreset_all", {17'd0, if0.aluop_ex, if0.signext_ex, if0.alusrc_ex, if0.regdst_ex,
            if0.memread_mem, if0.memwrite_mem, if0.branch_mem, if0.regwrite_wb, if0.memtoreg_wb,
            if0.valid_ex, if0.valid_mem, if0.valid_wb, if0.illegal_ex}, 64'd0);
        step(ADD, 1'b0, 1'b0, 1'b0);
        chk("post_reset_valid", 64'(if0.valid_ex), 64'd1);
        chk("post_reset_memwrite", 64'(if0.memwrite_mem), 64'd0);

        step(ILL, 1'b0, 1'b0, 1'b0);
        chk("illegal_flag", 64'(if0.illegal_ex), 64'd1);
        chk("illegal_ctl", 64'({if0.aluop_ex, if0.alusrc_ex, if0.regdst_ex}), 64'd0);
        step(ADDI, 1'b0, 1'b0, 1'b0);
        chk("addi_off_illegal", 64'(if1.illegal_ex), 64'd1);
        chk("addi_on_legal", 64'(if0.illegal_ex), 64'd0);
        step(ADD, 1'b0, 1'b0, 1'b0);
        step(ADD, 1'b0, 1'b0, 1'b0);
        chk("addi_off_regwrite", 64'(if1.regwrite_wb), 64'd0);
        chk("addi_on_regwrite", 64'(if0.regwrite_wb), 64'd1);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                4: op = 6'h08;
                default: op = 6'($urandom_range(0, 63));
            endcase
            step({op, 26'($urandom)}, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
